dot_product_sequencer: RTL and testbench
========================================

DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning operand-pair buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load_valid  input  1  operand pair presented.
REQ-005 SHALL have ports load_a, load_b  input  16 each  FP16 operand pair.
REQ-006 SHALL have port load_ready  output  1  pair accepted when load_valid && load_ready.
REQ-007 SHALL have port go  input  1  start a run over all buffered pairs.
REQ-008 SHALL have ports pe_start  output  1, pe_a, pe_b  output  16 each  drive to the downstream MAC processing unit.
REQ-009 SHALL have ports pe_ready  input  1, pe_p  input  16  MAC completion pulse and accumulated FP16 result.
REQ-010 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), result  output  16, count  output  $clog2(DEPTH)+1.
REQ-011 SHALL have port err  output  1, present only when the Configuration macro is defined.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, NEXT, FINISH.
REQ-013 load_ready SHALL be 1 only in IDLE with count < DEPTH and go low.
REQ-014 An accepted pair SHALL be written at index count; count SHALL then increment by 1.
REQ-015 When count == DEPTH, load_ready SHALL be 0 and load_valid SHALL be ignored without error.
REQ-016 In IDLE, go with count > 0 SHALL clear the read index, set busy, and enter ISSUE next cycle.
REQ-017 In IDLE, go with count == 0 SHALL enter FINISH directly without any pe_start, leaving result unchanged.
REQ-018 If go and load_valid are both high in IDLE, go SHALL win and the pair SHALL NOT be stored.
REQ-019 ISSUE SHALL assert pe_start for exactly one cycle with pe_a/pe_b = entry[read index], then enter WAIT.
REQ-020 pe_a/pe_b SHALL remain stable from ISSUE until pe_ready is sampled high.
REQ-021 WAIT SHALL stay until pe_ready == 1, then register pe_p into result and enter NEXT.
REQ-022 NEXT SHALL increment the read index, enter ISSUE if the index < count, else FINISH.
REQ-023 Each NEXT SHALL last exactly one cycle, so consecutive pe_start pulses are separated by at least one low cycle after pe_ready.
REQ-024 FINISH SHALL pulse done for one cycle, clear count to 0 and busy to 0, then return to IDLE.
REQ-025 busy SHALL be 1 in ISSUE, WAIT, NEXT, and FINISH, and 0 in IDLE.
REQ-026 go and pe_ready SHALL be ignored outside the states that consume them.
REQ-027 The block SHALL NOT perform arithmetic on FP16 data; result SHALL be pe_p as captured.

Reset
REQ-028 reset_n low SHALL immediately set state IDLE; pe_start, busy, done, and err SHALL be 0; result SHALL be 0x0000; count and the read index SHALL be 0; pe_a/pe_b SHALL be 0x0000.
REQ-029 Reset mid-run SHALL discard buffered pairs and any pending pe_ready.
REQ-030 Buffer contents SHALL NOT require a reset.

Configuration
REQ-031 With macro DPS_TIMEOUT_EN defined, a 6-bit watchdog SHALL count WAIT cycles.
REQ-032 With DPS_TIMEOUT_EN defined, reaching 63 cycles without pe_ready SHALL set err (sticky until reset), capture no result, and enter FINISH.
REQ-033 Without DPS_TIMEOUT_EN, the err port and the watchdog SHALL be absent, and WAIT SHALL wait indefinitely.

Verification
REQ-034 Load (0x3C00,0x4000),(0x4000,0x4200); go -> 2 pe_start pulses, pe_a 0x3C00 then 0x4000; with a bench MAC model, result = 0x4800 and done pulses once.
REQ-035 Load 8 pairs, then a 9th with load_valid=1 -> load_ready = 0, count stays 8; go issues exactly 8 pe_start pulses.
REQ-036 go with count = 0 -> done within 2 cycles, no pe_start, result unchanged.
REQ-037 go and load_valid high in the same cycle -> run starts, count before the run is unchanged, the pair is not stored.
REQ-038 Drop reset_n during WAIT of the 2nd of 4 pairs -> all outputs take reset values; a later go with no loads yields count 0.
REQ-039 With DPS_TIMEOUT_EN, pe_ready held low -> err = 1 and done pulses 64 cycles after pe_start.

Source files
------------

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - buffers FP16 operand pairs and sequences them through an external MAC unit
// Optional build macro DPS_TIMEOUT_EN adds a 6-bit WAIT watchdog and the sticky err output.
module dot_product_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_valid,
    input  logic [15:0]          load_a,
    input  logic [15:0]          load_b,
    output logic                 load_ready,
    input  logic                 go,
    output logic                 pe_start,
    output logic [15:0]          pe_a,
    output logic [15:0]          pe_b,
    input  logic                 pe_ready,
    input  logic [15:0]          pe_p,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          result,
    output logic [$clog2(DEPTH):0] count
`ifdef DPS_TIMEOUT_EN
    ,
    output logic                 err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_FINISH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rd_idx_q, rd_idx_d;
    logic            pe_start_q, pe_start_d;
    logic [15:0]     pe_a_q, pe_a_d;
    logic [15:0]     pe_b_q, pe_b_d;
    logic [15:0]     result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef DPS_TIMEOUT_EN
    logic [5:0]      wd_q, wd_d;
    logic            err_q, err_d;
`endif

    logic [15:0]     mem_a [DEPTH];
    logic [15:0]     mem_b [DEPTH];
    logic            load_fire;

    // go has priority over a same-cycle load, so loading is refused whenever go is high
    assign load_ready = (state_q == S_IDLE) && (count_q < DEPTH_C) && !go;
    assign load_fire  = load_valid && load_ready;

    // Operand buffer: plain storage, contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_a[count_q[AW-1:0]] <= load_a;
            mem_b[count_q[AW-1:0]] <= load_b;
        end
    end

    // Next-state and next-output computation; all outputs are registered from these
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        pe_a_d   = pe_a_q;
        pe_b_d   = pe_b_q;
        result_d = result_q;
`ifdef DPS_TIMEOUT_EN
        wd_d     = wd_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (count_q != '0) begin
                        rd_idx_d = '0;
                        state_d  = S_ISSUE;
                    end else begin
                        state_d  = S_FINISH;
                    end
                end else if (load_fire) begin
                    count_d = count_q + CW'(1);
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef DPS_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (pe_ready) begin
                    result_d = pe_p;
                    state_d  = S_NEXT;
                end
`ifdef DPS_TIMEOUT_EN
                else begin
                    wd_d = wd_q + 6'd1;
                    if (wd_d == 6'd63) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end
                end
`endif
            end
            S_NEXT: begin
                rd_idx_d = rd_idx_q + CW'(1);
                state_d  = (rd_idx_d < count_q) ? S_ISSUE : S_FINISH;
            end
            S_FINISH: begin
                count_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Operands are latched only on entry to ISSUE and held through WAIT
        if (state_d == S_ISSUE) begin
            pe_a_d = mem_a[rd_idx_d[AW-1:0]];
            pe_b_d = mem_b[rd_idx_d[AW-1:0]];
        end
        pe_start_d = (state_d == S_ISSUE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FINISH);
    end

    // Sequencer state register with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_idx_q   <= '0;
            pe_start_q <= 1'b0;
            pe_a_q     <= '0;
            pe_b_q     <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DPS_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_idx_q   <= rd_idx_d;
            pe_start_q <= pe_start_d;
            pe_a_q     <= pe_a_d;
            pe_b_q     <= pe_b_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DPS_TIMEOUT_EN
            wd_q       <= wd_d;
            err_q      <= err_d;
`endif
        end
    end

    assign pe_start = pe_start_q;
    assign pe_a     = pe_a_q;
    assign pe_b     = pe_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign count    = count_q;
`ifdef DPS_TIMEOUT_EN
    assign err      = err_q;
`endif

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - directed-vector bench for dot_product_sequencer with a scripted MAC responder
module tb_dot_product_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_a = '0;
    logic [15:0] load_b = '0;
    logic        load_ready;
    logic        go = 1'b0;
    logic        pe_start;
    logic [15:0] pe_a, pe_b;
    logic        pe_ready = 1'b0;
    logic [15:0] pe_p = '0;
    logic        busy, done;
    logic [15:0] result;
    logic [3:0]  count;
`ifdef DPS_TIMEOUT_EN
    logic        err;
`endif

    int n_vec = 0;
    int n_miss = 0;

    int cyc = 0, ndone = 0, nstart = 0, done_cyc = 0, start_cyc = 0;
    int lat = 0, resp_lat = 1, stab_bad = 0;
    bit pending = 0, hold_low = 0;
    logic [15:0] a_hold, b_hold;
    logic [15:0] st_a[$], st_b[$], resp_q[$];

    dot_product_sequencer #(.DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid), .load_a(load_a), .load_b(load_b), .load_ready(load_ready),
        .go(go), .pe_start(pe_start), .pe_a(pe_a), .pe_b(pe_b),
        .pe_ready(pe_ready), .pe_p(pe_p),
        .busy(busy), .done(done), .result(result), .count(count)
`ifdef DPS_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // MAC responder and event monitor, sampled 1ns after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        pe_ready = 1'b0;
        if (!reset_n) begin
            pending = 0;
        end else begin
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (pe_start) begin
                nstart++;
                st_a.push_back(pe_a);
                st_b.push_back(pe_b);
                start_cyc = cyc;
                a_hold = pe_a;
                b_hold = pe_b;
                pending = 1;
                lat = resp_lat;
            end else if (pending && !hold_low) begin
                if (lat == 0) begin
                    pe_ready = 1'b1;
                    if (resp_q.size() > 0) pe_p = resp_q.pop_front();
                    else pe_p = 16'h0000;
                    pending = 0;
                    if (pe_a !== a_hold || pe_b !== b_hold) stab_bad++;
                end else begin
                    lat--;
                end
            end
        end
    end

    task automatic load_pair(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        load_valid = 1'b1; load_a = a; load_b = b;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic do_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        for (int i = 0; i < budget && ndone == base; i++) @(negedge clk);
        chk(tag, 32'(ndone > base), 32'd1);
    endtask

    initial begin
        int base_d, base_s;
        logic [15:0] r_before;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pe_start", pe_start, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_count", count, 0);
        chk("rst_pe_a", pe_a, 16'h0000);
        chk("rst_load_ready", load_ready, 1);
`ifdef DPS_TIMEOUT_EN
        chk("rst_err", err, 0);
`endif

        // Two-pair dot product: 1*2 = 2.0, then 2.0 + 2*3 = 8.0
        resp_q = '{16'h4000, 16'h4800};
        load_pair(16'h3C00, 16'h4000);
        load_pair(16'h4000, 16'h4200);
        chk("t1_count", count, 2);
        base_d = ndone; base_s = nstart;
        do_go();
        wait_done("t1_done_seen", base_d, 60);
        repeat (3) @(negedge clk);
        chk("t1_nstart", nstart - base_s, 2);
        chk("t1_a0", st_a[base_s], 16'h3C00);
        chk("t1_b0", st_b[base_s], 16'h4000);
        chk("t1_a1", st_a[base_s+1], 16'h4000);
        chk("t1_b1", st_b[base_s+1], 16'h4200);
        chk("t1_result", result, 16'h4800);
        chk("t1_done_once", ndone - base_d, 1);
        chk("t1_count_clr", count, 0);
        chk("t1_busy_clr", busy, 0);

        // Fill to DEPTH, then a 9th pair must be refused
        for (int i = 0; i < 8; i++) begin
            resp_q.push_back(16'h1000 + 16'(i));
            load_pair(16'h0100 + 16'(i), 16'h0200 + 16'(i));
        end
        chk("t2_count_full", count, 8);
        @(negedge clk);
        load_valid = 1'b1; load_a = 16'hDEAD; load_b = 16'hBEEF;
        #1;
        chk("t2_ready_full", load_ready, 0);
        @(negedge clk);
        load_valid = 1'b0;
        chk("t2_count_stay", count, 8);
        base_d = ndone; base_s = nstart;
        do_go();
        wait_done("t2_done_seen", base_d, 120);
        chk("t2_nstart", nstart - base_s, 8);
        chk("t2_a7", st_a[base_s+7], 16'h0107);
        chk("t2_result", result, 16'h1007);

        // go with an empty buffer
        r_before = result;
        base_d = ndone; base_s = nstart;
        do_go();
        wait_done("t3_done_fast", base_d, 0);
        chk("t3_no_start", nstart - base_s, 0);
        chk("t3_result_kept", result, r_before);
        chk("t3_count", count, 0);

        // go wins over a same-cycle load
        resp_q = '{16'h5555};
        load_pair(16'h1111, 16'h2222);
        base_d = ndone; base_s = nstart;
        @(negedge clk);
        go = 1'b1; load_valid = 1'b1; load_a = 16'hAAAA; load_b = 16'hBBBB;
        @(negedge clk);
        go = 1'b0; load_valid = 1'b0;
        chk("t4_count_run", count, 1);
        wait_done("t4_done_seen", base_d, 40);
        chk("t4_nstart", nstart - base_s, 1);
        chk("t4_a0", st_a[base_s], 16'h1111);
        chk("t4_result", result, 16'h5555);

        // Reset while waiting on the 2nd of 4 pairs
        resp_lat = 5;
        resp_q = '{16'h1234, 16'h2345, 16'h3456, 16'h4567};
        for (int i = 0; i < 4; i++) load_pair(16'h3000 + 16'(i), 16'h3100 + 16'(i));
        base_s = nstart;
        do_go();
        for (int i = 0; i < 60 && (nstart - base_s) < 2; i++) @(negedge clk);
        chk("t5_second_issue", nstart - base_s, 2);
        @(negedge clk);
        chk("t5_ready_busy", load_ready, 0);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_pe_start", pe_start, 0);
        chk("t5_rst_result", result, 16'h0000);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_pe_a", pe_a, 16'h0000);
        chk("t5_rst_pe_b", pe_b, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        resp_q.delete();
        resp_lat = 1;
        base_d = ndone; base_s = nstart;
        do_go();
        wait_done("t5_done_after", base_d, 10);
        chk("t5_no_start", nstart - base_s, 0);
        chk("t5_count", count, 0);
        chk("t5_result", result, 16'h0000);

`ifdef DPS_TIMEOUT_EN
        // Watchdog: no pe_ready ever arrives
        hold_low = 1;
        load_pair(16'h3C00, 16'h3C00);
        base_d = ndone;
        do_go();
        wait_done("to_done_seen", base_d, 120);
        chk("to_latency", done_cyc - start_cyc, 64);
        chk("to_err", err, 1);
        chk("to_result", result, 16'h0000);
        hold_low = 0;
`endif

        repeat (2) @(negedge clk);
        chk("pe_ab_stable", stab_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
